// File: rtl/threshold_config_master.sv
// Threshold shadow table with bulk load into the filter, single-channel host readback, and
// optional post-load readback verify (enabled by defining THRESHOLD_READBACK_VERIFY_EN).
module threshold_config_master #(
    parameter int unsigned            N_CH       = 40,
    parameter int unsigned            CH_W       = 8,
    parameter int unsigned            TH_W       = 32,
    parameter logic signed [TH_W-1:0] DEFAULT_TH = TH_W'(99999)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cfg_we,
    input  logic [5:0]             cfg_addr,
    input  logic signed [TH_W-1:0] cfg_data,
    output logic                   cfg_wr_err,
    input  logic                   start,
    input  logic                   rd_req,
    input  logic [5:0]             rd_ch,
    output logic                   rd_valid,
    output logic signed [TH_W-1:0] rd_data,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [5:0]             err_ch,
    output logic [5:0]             err_count,
    output logic                   write_threshold_value,
    output logic [CH_W-1:0]        threshold_ch,
    output logic signed [TH_W-1:0] threshold_value,
    input  logic signed [TH_W-1:0] threshold_value_read
);

    localparam logic [5:0] NChIdx = 6'(N_CH);
    localparam logic [5:0] LastCh = 6'(N_CH - 1);

    typedef enum logic [2:0] {
        StIdle, StWrite, StVerify, StDrain, StFin, StHrd, StHrdWait
    } state_t;

    state_t                 state;
    logic [5:0]             ch_q;
    logic [5:0]             ch_nxt;
    logic                   host_oob_q;
    logic signed [TH_W-1:0] shadow [N_CH];

    assign ch_nxt = ch_q + 6'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) shadow[i] <= DEFAULT_TH;
        end else if (cfg_we && !busy && cfg_addr < NChIdx) begin
            shadow[cfg_addr] <= cfg_data;
        end
    end

`ifdef THRESHOLD_READBACK_VERIFY_EN
    // Readback of the channel driven in the previous cycle lands one cycle later.
    logic       chk_vld_q;
    logic [5:0] chk_ch_q;
`else
    assign error     = 1'b0;
    assign err_ch    = '0;
    assign err_count = '0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                 <= StIdle;
            ch_q                  <= '0;
            host_oob_q            <= 1'b0;
            cfg_wr_err            <= 1'b0;
            rd_valid              <= 1'b0;
            rd_data               <= '0;
            busy                  <= 1'b0;
            done                  <= 1'b0;
            write_threshold_value <= 1'b0;
            threshold_ch          <= '0;
            threshold_value       <= '0;
`ifdef THRESHOLD_READBACK_VERIFY_EN
            chk_vld_q             <= 1'b0;
            chk_ch_q              <= '0;
            error                 <= 1'b0;
            err_ch                <= '0;
            err_count             <= '0;
`endif
        end else begin
            cfg_wr_err <= cfg_we & busy;
            rd_valid   <= 1'b0;
            done       <= 1'b0;
`ifdef THRESHOLD_READBACK_VERIFY_EN
            chk_vld_q  <= (state == StVerify);
            chk_ch_q   <= ch_q;
            if (chk_vld_q && threshold_value_read != shadow[chk_ch_q]) begin
                err_count <= err_count + 6'd1;
                if (!error) begin
                    error  <= 1'b1;
                    err_ch <= chk_ch_q;
                end
            end
`endif
            unique case (state)
                StIdle: begin
                    write_threshold_value <= 1'b0;
                    threshold_ch          <= '0;
                    if (start) begin
                        state                 <= StWrite;
                        busy                  <= 1'b1;
                        ch_q                  <= '0;
                        write_threshold_value <= 1'b1;
                        threshold_value       <= shadow[0];
`ifdef THRESHOLD_READBACK_VERIFY_EN
                        error                 <= 1'b0;
                        err_ch                <= '0;
                        err_count             <= '0;
`endif
                    end else if (rd_req) begin
                        state      <= StHrd;
                        busy       <= 1'b1;
                        host_oob_q <= (rd_ch >= NChIdx);
                        if (rd_ch < NChIdx) threshold_ch <= CH_W'(rd_ch);
                    end
                end
                StWrite: begin
                    if (ch_q == LastCh) begin
                        write_threshold_value <= 1'b0;
                        threshold_ch          <= '0;
                        ch_q                  <= '0;
`ifdef THRESHOLD_READBACK_VERIFY_EN
                        state                 <= StVerify;
`else
                        state                 <= StFin;
                        busy                  <= 1'b0;
                        done                  <= 1'b1;
`endif
                    end else begin
                        ch_q            <= ch_nxt;
                        threshold_ch    <= CH_W'(ch_nxt);
                        threshold_value <= shadow[ch_nxt];
                    end
                end
                StVerify: begin
                    if (ch_q == LastCh) begin
                        state        <= StDrain;
                        threshold_ch <= '0;
                    end else begin
                        ch_q         <= ch_nxt;
                        threshold_ch <= CH_W'(ch_nxt);
                    end
                end
                StDrain: begin
                    state <= StFin;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                StFin: begin
                    state <= StIdle;
                end
                StHrd: begin
                    state <= StHrdWait;
                end
                StHrdWait: begin
                    state        <= StIdle;
                    busy         <= 1'b0;
                    rd_valid     <= 1'b1;
                    rd_data      <= host_oob_q ? '0 : threshold_value_read;
                    threshold_ch <= '0;
                end
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_threshold_config_master.sv
// Randomized scoreboard bench for threshold_config_master with a behavioural filter model.
module tb_threshold_config_master;

    localparam int N_CH       = 40;
    localparam int CH_W       = 8;
    localparam int TH_W       = 32;
    localparam int DEFAULT_TH = 99999;
`ifdef THRESHOLD_READBACK_VERIFY_EN
    localparam bit VERIFY   = 1'b1;
    localparam int DONE_LAT = 2 * N_CH + 1;
`else
    localparam bit VERIFY   = 1'b0;
    localparam int DONE_LAT = N_CH;
`endif

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   cfg_we;
    logic [5:0]             cfg_addr;
    logic signed [TH_W-1:0] cfg_data;
    logic                   cfg_wr_err;
    logic                   start;
    logic                   rd_req;
    logic [5:0]             rd_ch;
    logic                   rd_valid;
    logic signed [TH_W-1:0] rd_data;
    logic                   busy;
    logic                   done;
    logic                   error;
    logic [5:0]             err_ch;
    logic [5:0]             err_count;
    logic                   write_threshold_value;
    logic [CH_W-1:0]        threshold_ch;
    logic signed [TH_W-1:0] threshold_value;
    logic signed [TH_W-1:0] threshold_value_read;

    threshold_config_master dut (
        .clk                  (clk),
        .reset                (reset),
        .cfg_we               (cfg_we),
        .cfg_addr             (cfg_addr),
        .cfg_data             (cfg_data),
        .cfg_wr_err           (cfg_wr_err),
        .start                (start),
        .rd_req               (rd_req),
        .rd_ch                (rd_ch),
        .rd_valid             (rd_valid),
        .rd_data              (rd_data),
        .busy                 (busy),
        .done                 (done),
        .error                (error),
        .err_ch               (err_ch),
        .err_count            (err_count),
        .write_threshold_value(write_threshold_value),
        .threshold_ch         (threshold_ch),
        .threshold_value      (threshold_value),
        .threshold_value_read (threshold_value_read)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Filter model: holds writes across master resets; corrupt[] is XORed into readback.
    int filt [N_CH] = '{default: DEFAULT_TH};
    int corrupt [N_CH] = '{default: 0};
    always @(posedge clk) begin
        if (threshold_ch < 8'(N_CH)) begin
            if (write_threshold_value) filt[threshold_ch] <= threshold_value;
            else threshold_value_read <= filt[threshold_ch] ^ corrupt[threshold_ch];
        end
    end

    typedef struct { int cyc; bit err; int ech; int ecnt; } done_t;
    typedef struct { int cyc; int data; } rd_t;
    done_t done_q[$];
    rd_t   rd_q[$];
    int    werr_q[$];

    int vectors = 0;
    int miscompares = 0;
    int shadow_m [N_CH];
    int loaded_m [N_CH];

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    done_t md;
    rd_t   mr;
    int    mw;
    always @(negedge clk) begin
        if (!reset) begin
            if (done) begin
                check("done expected", done_q.size() != 0, 1);
                if (done_q.size() != 0) begin
                    md = done_q.pop_front();
                    check("done cycle", cyc, md.cyc);
                    check("busy at done", busy, 0);
                    check("error", error, md.err);
                    check("err_ch", err_ch, md.ech);
                    check("err_count", err_count, md.ecnt);
                end
            end
            if (rd_valid) begin
                check("rd_valid expected", rd_q.size() != 0, 1);
                if (rd_q.size() != 0) begin
                    mr = rd_q.pop_front();
                    check("rd_valid cycle", cyc, mr.cyc);
                    check("rd_data", rd_data, mr.data);
                    check("busy at rd_valid", busy, 0);
                end
            end
            if (cfg_wr_err) begin
                check("cfg_wr_err expected", werr_q.size() != 0, 1);
                if (werr_q.size() != 0) begin
                    mw = werr_q.pop_front();
                    check("cfg_wr_err cycle", cyc, mw);
                end
            end
        end
    end

    task automatic apply_reset();
        reset = 1'b1;
        #1;
        check("reset ctrl", {cfg_wr_err, rd_valid, busy, done, error, err_ch, err_count,
                             write_threshold_value, threshold_ch}, 0);
        check("reset data", rd_data | threshold_value, 0);
        done_q.delete();
        rd_q.delete();
        werr_q.delete();
        for (int k = 0; k < N_CH; k++) shadow_m[k] = DEFAULT_TH;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic cfg_write(input int addr, input int data);
        cfg_we   = 1'b1;
        cfg_addr = 6'(addr);
        cfg_data = data;
        if (addr < N_CH) shadow_m[addr] = data;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic host_read(input int ch);
        rd_t r;
        int  t0;
        t0     = cyc + 1;
        r.cyc  = t0 + 2;
        r.data = (ch < N_CH) ? loaded_m[ch] : 0;
        rd_q.push_back(r);
        rd_req = 1'b1;
        rd_ch  = 6'(ch);
        @(negedge clk);
        rd_req = 1'b0;
        check("hrd threshold_ch", threshold_ch, (ch < N_CH) ? ch : 0);
        check("hrd strobe", write_threshold_value, 0);
        check("hrd busy", busy, 1);
        for (int i = 0; i < 20 && rd_q.size() != 0; i++) @(negedge clk);
        check("rd_valid timeout", rd_q.size(), 0);
        rd_q.delete();
        @(negedge clk);
    endtask

    // inj_at: offset at which a cfg_we, start and rd_req are thrown at the busy master.
    task automatic do_load(input bit [N_CH-1:0] cmask, input int inj_at, input int rst_at,
                           input bit rd_too);
        done_t d;
        int    snap [N_CH];
        int    t0;
        int    cnt;
        int    first;
        cnt   = 0;
        first = 0;
        for (int k = 0; k < N_CH; k++) begin
            snap[k]    = shadow_m[k];
            corrupt[k] = cmask[k] ? 32'h100 : 0;
            if (cmask[k]) begin
                if (cnt == 0) first = k;
                cnt++;
            end
        end
        t0     = cyc + 1;
        d.cyc  = t0 + DONE_LAT;
        d.err  = VERIFY && cnt > 0;
        d.ech  = VERIFY ? first : 0;
        d.ecnt = VERIFY ? cnt : 0;
        done_q.push_back(d);
        start  = 1'b1;
        rd_req = rd_too;
        rd_ch  = 6'd3;
        @(negedge clk);
        start  = 1'b0;
        rd_req = 1'b0;
        for (int o = 0; o < 200; o++) begin
            if (o < N_CH) begin
                check("load busy", busy, 1);
                check("load strobe", write_threshold_value, 1);
                check("load ch", threshold_ch, o);
                check("load value", threshold_value, snap[o]);
            end
            if (o == inj_at) begin
                cfg_we   = 1'b1;
                cfg_addr = 6'($urandom_range(0, N_CH - 1));
                cfg_data = 777;
                start    = 1'b1;
                rd_req   = 1'b1;
                rd_ch    = 6'd1;
                werr_q.push_back(t0 + o + 1);
            end
            if (o == rst_at) begin
                apply_reset();
                break;
            end
            if (done_q.size() == 0) break;
            @(negedge clk);
            cfg_we = 1'b0;
            start  = 1'b0;
            rd_req = 1'b0;
        end
        check("done timeout", done_q.size(), 0);
        done_q.delete();
        @(negedge clk);
        check("cfg_wr_err pending", werr_q.size(), 0);
        werr_q.delete();
        for (int k = 0; k < N_CH; k++) corrupt[k] = 0;
        loaded_m = snap;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench still running at %0t, expected finish", $time);
        $fatal(1);
    end

    initial begin
        bit [N_CH-1:0] m;
        reset  = 1'b1;
        cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        start  = 1'b0; rd_req = 1'b0; rd_ch = '0;
        for (int k = 0; k < N_CH; k++) loaded_m[k] = DEFAULT_TH;
        @(negedge clk);
        apply_reset();

        do_load('0, -1, -1, 1'b0);
        cfg_write(5, -1200);
        do_load('0, -1, -1, 1'b0);

        m = '0; m[7] = 1'b1; m[30] = 1'b1;
        do_load(m, -1, -1, 1'b0);
        do_load('0, -1, -1, 1'b0);

        cfg_write(12, 4321);
        cfg_write(45, 555);
        do_load('0, -1, -1, 1'b0);
        host_read(12);
        host_read(45);

        do_load('0, 10, -1, 1'b0);
        do_load('0, -1, 19, 1'b0);
        do_load('0, -1, -1, 1'b0);
        do_load('0, -1, -1, 1'b1);

        for (int it = 0; it < 8; it++) begin
            int nw;
            nw = $urandom_range(2, 5);
            for (int w = 0; w < nw; w++) cfg_write($urandom_range(0, 47), int'($urandom));
            host_read($urandom_range(0, 47));
            m = '0;
            for (int b = 0; b < $urandom_range(0, 3); b++) m[$urandom_range(0, N_CH - 1)] = 1'b1;
            do_load(m, ($urandom_range(0, 1) == 1) ? $urandom_range(5, N_CH - 5) : -1, -1,
                    1'($urandom_range(0, 1)));
            host_read($urandom_range(0, 47));
        end

        check("leftover done", done_q.size(), 0);
        check("leftover rd", rd_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/threshold_config_master.md
# threshold_config_master

Initiator for the self-trigger threshold register port of the 40-channel pedestal-recovery/trigger filter block. Holds a 40-entry shadow table written by the slow-control bus and, on command, pushes every entry into the filter's threshold registers one channel per cycle. Optionally reads each entry back and compares it against the shadow. Also services single-channel host readbacks through the same port. Sits between the slow-control register decoder and the filter/trigger block.

## Interface
- N_CH, 40: number of trigger channels.
- CH_W, 8: width of the channel index on the filter port.
- TH_W, 32: threshold width, signed.
- DEFAULT_TH, 99999: shadow value after reset; matches the filter's reset threshold.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- cfg_we  in  1  shadow write strobe.
- cfg_addr  in  6  shadow index.
- cfg_data  in  TH_W  signed threshold to store.
- cfg_wr_err  out  1  1-cycle pulse: a cfg_we was rejected because busy=1.
- start  in  1  1-cycle pulse: load all N_CH thresholds.
- rd_req  in  1  1-cycle pulse: host readback request.
- rd_ch  in  6  channel for rd_req.
- rd_valid  out  1  1-cycle pulse: rd_data is valid.
- rd_data  out  TH_W  readback value.
- busy  out  1  high during a load or a host read.
- done  out  1  1-cycle pulse at the end of a load.
- error  out  1  sticky verify mismatch; cleared by the next accepted start.
- err_ch  out  6  first mismatching channel.
- err_count  out  6  number of mismatching channels in the last load.
- write_threshold_value  out  1  to filter: write strobe.
- threshold_ch  out  CH_W  to filter: channel index.
- threshold_value  out  TH_W  to filter: value to write.
- threshold_value_read  in  TH_W  from filter: registered readback of threshold_ch, 1-cycle latency, updated only while write_threshold_value=0.

## Operation
- All outputs are registered.
- Reset values:
  - All outputs are 0.
  - Shadow entries are DEFAULT_TH.
  - FSM is in IDLE.
- States:
  - IDLE: drives write_threshold_value=0 and threshold_ch=0.
  - WRITE: walks ch 0..N_CH-1, one per cycle, with write_threshold_value=1 and threshold_value=shadow[ch]. After ch N_CH-1 goes to VERIFY, or to FIN when verify is compiled out.
  - VERIFY: walks ch 0..N_CH-1 with write_threshold_value=0. Goes to FIN when the last compare is taken.
  - FIN: pulses done for one cycle, then returns to IDLE.
  - HRD: single host read, then returns to IDLE.
- Verify compare:
  - Sample threshold_value_read in the cycle after ch k is driven and compare it to shadow[k].
  - On mismatch, increment err_count. On the first mismatch only, set error and err_ch=k.
- start is accepted only in IDLE. Acceptance clears error, err_ch and err_count.
- start while busy is ignored.
- start and rd_req in the same IDLE cycle: start wins and rd_req is dropped (no rd_valid).
- cfg_we:
  - When busy=0, writes the shadow.
  - When busy=1, the shadow is not written and cfg_wr_err pulses.
  - cfg_addr >= N_CH is silently ignored.
- rd_req in IDLE with rd_ch < N_CH: drive threshold_ch=rd_ch, write_threshold_value=0, capture threshold_value_read 2 cycles later, pulse rd_valid.
- rd_req with rd_ch >= N_CH: no filter access; rd_valid pulses with rd_data=0.
- rd_req while busy is ignored.
- Reset mid-load aborts immediately. The filter keeps any partial writes already made; the shadow returns to DEFAULT_TH.

## Timing
- start sampled at edge t0: strobe high for cycles t0+1..t0+40 (ch 0..39).
- VERIFY drives cycles t0+41..t0+80; the last compare is at t0+81.
- done pulses at t0+82, the same cycle busy falls. Total busy: 81 cycles.
- Verify compiled out: strobe high for t0+1..t0+40; done and busy falling at t0+41.
- Host read: rd_req at t0, threshold_ch valid at t0+1, filter register updated at edge t0+2, rd_valid and rd_data at t0+3. busy is high for t0+1..t0+2.

## Configuration
- THRESHOLD_READBACK_VERIFY_EN defined: VERIFY state and compare logic are present.
- THRESHOLD_READBACK_VERIFY_EN undefined:
  - WRITE goes directly to FIN.
  - error, err_ch and err_count are tied to 0.
  - Host reads still work.

## Test plan
- Reset, then start with no cfg writes -> 40 strobes carrying 99999, done at t0+82, error=0, err_count=0.
- Write cfg_addr=5 with -1200, start -> threshold_ch=5 with threshold_value=-1200 at cycle t0+6; no mismatch.
- Filter model corrupts ch 7 and ch 30 on readback -> error=1, err_ch=7, err_count=2. A following clean start clears all three.
- rd_req rd_ch=12 after loading 4321 -> rd_valid at t0+3 with rd_data=4321. Same with rd_ch=45 -> rd_data=0 and no threshold_ch change.
- cfg_we and start during a load -> cfg_wr_err pulse, shadow unchanged, load not restarted. Then assert reset at t0+20 -> all outputs 0 immediately, and the next start completes normally.
